timer_counter: RTL and testbench

- Memory-mapped down-counting timer that sits on the device side of the system bridge.
- Two instances exist (TC1 at 0x7F00–0x7F0B, TC2 at 0x7F10–0x7F1B). The bridge decodes the address, forwards the per-device write enable, and muxes this block's read data back to the CPU.
- Each instance raises an interrupt line that the bridge maps onto hwint.

---
 rtl/timer_counter.sv | 105 ++++++++++
 tb/tb_timer_counter.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT registers behind the bridge,
// a four-state count FSM, and a maskable interrupt flag.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_addr;

    assign en          = ctrl[0];
    assign mode        = ctrl[2:1];
    assign im          = ctrl[3];
    assign ctrl_wr     = we && (addr[1:0] == 2'b00);
    assign preset_wr   = we && (addr[1:0] == 2'b01);
    assign unused_addr = ^addr[29:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset <= din;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (mode == 2'b01) begin
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl[0] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed last so a software CTRL write overrides both the FSM's
            // EN clear and a same-cycle irq_flag set.
            if (ctrl_wr) begin
                ctrl     <= din[3:0];
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = '0;
        case (addr[1:0])
            2'b00:   dout = {28'd0, ctrl};
            2'b01:   dout = preset;
            2'b10:   dout = count;
            default: dout = '0;
        endcase
    end

    assign irq = irq_flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: randomized runs compared against
// closed-form timing arithmetic (load at E2, period max(N,1)+3, irq at E(max(N,1)+2)).
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (edge index k counts from the enabling write E0)
    function automatic int eff_n(input logic [31:0] n);
        return (n == 32'd0) ? 1 : int'(n);
    endfunction

    function automatic logic [31:0] model_count(input logic [31:0] n, input bit reload, input int k);
        int m;
        int p;
        m = eff_n(n);
        if (k < 2) return '0;
        p = k - 2;
        if (reload) p = p % (m + 3);
        return (p < m) ? n - 32'(p) : '0;
    endfunction

    function automatic bit model_flag(input logic [31:0] n, input bit reload, input int k);
        int m;
        int p;
        m = eff_n(n);
        if (k < 2) return 1'b0;
        p = k - 2;
        if (reload) return (p % (m + 3)) == m;
        return p >= m;
    endfunction

    // ---------------- bus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        addr = {28'($urandom()), off};
        din  = data;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we  = 1'b0;
        din = '0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] data);
        addr = {28'($urandom()), off};
        #1;
        data = dout;
    endtask

    task automatic do_reset();
        we    = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        we    = 1'b0;
        repeat (3) tick();
        for (int unsigned off = 0; off < 4; off++) begin
            rd(2'(off), v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL reset_read off=%0d got=%h exp=%h", off, v, 32'd0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        reset = 1'b1;
        repeat (4) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle count=%h irq=%b exp count=0 irq=0", v, irq);
        end
    endtask

    task automatic test_one_shot(input logic [31:0] n);
        logic [31:0] v;
        int m;
        m = eff_n(n);
        do_reset();
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= m + 5; k++) begin
            tick();
            rd(2'd2, v);
            checks++;
            if (v !== model_count(n, 1'b0, k) || irq !== model_flag(n, 1'b0, k)) begin
                failures++;
                $display("FAIL one_shot n=%0d E%0d count=%h irq=%b exp count=%h irq=%b",
                         n, k, v, irq, model_count(n, 1'b0, k), model_flag(n, 1'b0, k));
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            failures++;
            $display("FAIL one_shot_ctrl got=%h exp=%h", v, 32'h8);
        end
        wr(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL one_shot_clear irq=%b exp=0", irq);
        end
        repeat (3) tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL one_shot_stay_clear irq=%b exp=0", irq);
        end
    endtask

    task automatic test_auto_reload(input logic [31:0] n);
        logic [31:0] v;
        int m;
        int pulses;
        m      = eff_n(n);
        pulses = 0;
        do_reset();
        wr(2'd1, n);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 2 + 4 * (m + 3); k++) begin
            tick();
            rd(2'd2, v);
            if (irq === 1'b1) pulses++;
            checks++;
            if (v !== model_count(n, 1'b1, k) || irq !== model_flag(n, 1'b1, k)) begin
                failures++;
                $display("FAIL auto_reload n=%0d E%0d count=%h irq=%b exp count=%h irq=%b",
                         n, k, v, irq, model_count(n, 1'b1, k), model_flag(n, 1'b1, k));
            end
        end
        checks++;
        if (pulses !== 4) begin
            failures++;
            $display("FAIL auto_reload_pulses got=%0d exp=4", pulses);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'hB) begin
            failures++;
            $display("FAIL auto_reload_ctrl got=%h exp=%h", v, 32'hB);
        end
    endtask

    task automatic test_mask();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd(2'd2, v);
            checks++;
            if (irq !== 1'b0 || v !== model_count(32'd1, 1'b0, k)) begin
                failures++;
                $display("FAIL mask E%0d irq=%b count=%h exp irq=0 count=%h",
                         k, irq, v, model_count(32'd1, 1'b0, k));
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL mask_ctrl got=%h exp=%h", v, 32'h0);
        end
    endtask

    // Pausing write lands on edge Es, the edge at which COUNT becomes n-(s-2).
    task automatic test_pause(input logic [31:0] n, input int s);
        logic [31:0] v;
        logic [31:0] frozen;
        frozen = n - 32'(s - 2);
        do_reset();
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 1; k < s; k++) tick();
        wr(2'd0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            rd(2'd2, v);
            checks++;
            if (v !== frozen || irq !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold n=%0d s=%0d count=%h irq=%b exp count=%h irq=0",
                         n, s, v, irq, frozen);
            end
            tick();
        end
        wr(2'd0, 32'h9);
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== frozen) begin
            failures++;
            $display("FAIL pause_resume_e1 count=%h exp=%h", v, frozen);
        end
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== n) begin
            failures++;
            $display("FAIL pause_resume_reload count=%h exp=%h", v, n);
        end
    endtask

    task automatic test_edge_values();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL max_load count=%h exp=%h", v, 32'hFFFF_FFFF);
        end
        tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL max_first_dec count=%h exp=%h", v, 32'hFFFF_FFFE);
        end
        wr(2'd2, $urandom());
        rd(2'd2, v);
        checks++;
        if (v !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL count_write_ignored count=%h exp=%h", v, 32'hFFFF_FFFD);
        end
        wr(2'd3, $urandom() | 32'h1);
        rd(2'd2, v);
        checks++;
        if (v !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL rsvd_write_count count=%h exp=%h", v, 32'hFFFF_FFFC);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL rsvd_read got=%h exp=%h", v, 32'h0);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL rsvd_write_ctrl got=%h exp=%h", v, 32'h1);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL rsvd_write_preset got=%h exp=%h", v, 32'hFFFF_FFFF);
        end
        wr(2'd0, 32'hABCD_EF04);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h4) begin
            failures++;
            $display("FAIL ctrl_upper_bits got=%h exp=%h", v, 32'h4);
        end
    endtask

    task automatic test_preset_midcount();
        logic [31:0] v;
        logic [31:0] exp_c;
        bit          exp_i;
        int          shift;
        shift = eff_n(32'd4) + 3;
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= shift + 12; k++) begin
            if (k == 3) wr(2'd1, 32'd7);
            else tick();
            if (k < shift + 2) begin
                exp_c = model_count(32'd4, 1'b1, k);
                exp_i = model_flag(32'd4, 1'b1, k);
            end else begin
                exp_c = model_count(32'd7, 1'b1, k - shift);
                exp_i = model_flag(32'd7, 1'b1, k - shift);
            end
            rd(2'd2, v);
            checks++;
            if (v !== exp_c || irq !== exp_i) begin
                failures++;
                $display("FAIL preset_midcount E%0d count=%h irq=%b exp count=%h irq=%b",
                         k, v, irq, exp_c, exp_i);
            end
        end
    endtask

    task automatic test_int_priority(input logic [31:0] n);
        logic [31:0] v;
        int m;
        m = eff_n(n);
        // CTRL write on the edge that leaves INT: software EN survives
        do_reset();
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= m + 2; k++) tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL int_prio_irq_up irq=%b exp=1", irq);
        end
        wr(2'd0, 32'h9);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h9 || irq !== 1'b0) begin
            failures++;
            $display("FAIL int_prio_ctrl ctrl=%h irq=%b exp ctrl=%h irq=0", v, irq, 32'h9);
        end
        for (int k = 1; k <= m + 3; k++) begin
            tick();
            rd(2'd2, v);
            checks++;
            if (v !== model_count(n, 1'b0, k) || irq !== model_flag(n, 1'b0, k)) begin
                failures++;
                $display("FAIL int_prio_rerun E%0d count=%h irq=%b exp count=%h irq=%b",
                         k, v, irq, model_count(n, 1'b0, k), model_flag(n, 1'b0, k));
            end
        end
        // CTRL write on the same edge the flag would set: the write wins
        do_reset();
        wr(2'd1, n);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= m + 1; k++) tick();
        wr(2'd0, 32'h9);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_clear irq=%b exp=0", irq);
        end
        tick();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8 || irq !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_after ctrl=%h irq=%b exp ctrl=%h irq=0", v, irq, 32'h8);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        logic [31:0] n;
        n = 32'($urandom_range(8, 20));
        do_reset();
        wr(2'd1, n);
        wr(2'd0, 32'hB);
        repeat (4) tick();
        rd(2'd2, v);
        checks++;
        if (v !== n - 32'd2) begin
            failures++;
            $display("FAIL async_pre count=%h exp=%h", v, n - 32'd2);
        end
        reset = 1'b0;
        #1;
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL async_count count=%h exp=0", v);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL async_ctrl ctrl=%h exp=0", v);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL async_preset preset=%h exp=0", v);
        end
        // irq held high in one-shot mode, then reset between edges
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL async_irq_pre irq=%b exp=1", irq);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL async_irq irq=%b exp=0", irq);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_random_runs();
        logic [31:0] v;
        logic [31:0] n;
        logic [1:0]  md;
        bit          imk;
        bit          rl;
        logic [31:0] c;
        logic [31:0] exp_ctrl;
        int          m;
        for (int r = 0; r < 8; r++) begin
            n   = 32'($urandom_range(0, 12));
            md  = 2'($urandom_range(0, 3));
            imk = 1'($urandom_range(0, 1));
            rl  = (md == 2'b01);
            c   = {28'd0, imk, md, 1'b1};
            m   = eff_n(n);
            do_reset();
            wr(2'd1, n);
            wr(2'd0, c);
            for (int k = 1; k <= 2 + 2 * (m + 3); k++) begin
                tick();
                rd(2'd2, v);
                checks++;
                if (v !== model_count(n, rl, k) || irq !== (model_flag(n, rl, k) & imk)) begin
                    failures++;
                    $display("FAIL random r=%0d n=%0d ctrl=%h E%0d count=%h irq=%b exp count=%h irq=%b",
                             r, n, c, k, v, irq, model_count(n, rl, k), model_flag(n, rl, k) & imk);
                end
            end
            exp_ctrl = rl ? c : (c & ~32'h1);
            rd(2'd0, v);
            checks++;
            if (v !== exp_ctrl) begin
                failures++;
                $display("FAIL random_ctrl r=%0d got=%h exp=%h", r, v, exp_ctrl);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        test_reset();
        test_one_shot(32'd3);
        test_one_shot(32'd0);
        test_one_shot(32'($urandom_range(1, 15)));
        test_auto_reload(32'd2);
        test_auto_reload(32'($urandom_range(1, 6)));
        test_mask();
        test_pause(32'd10, 6);
        test_pause(32'($urandom_range(12, 20)), $urandom_range(3, 11));
        test_edge_values();
        test_preset_midcount();
        test_int_priority(32'd3);
        test_int_priority(32'd0);
        test_async_reset();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
